// File: rtl/axi4lite_read_master.sv
// AXI4-Lite single-outstanding read initiator: one command in, one AR/R transaction out, one response pulse back.
// Latency: 3 cycles from command accept to rsp_valid with a zero-wait slave; each slave wait cycle adds one.
// Backpressure: cmd_ready only while idle; a slave that stalls a phase for pTIMEOUT cycles is abandoned with an error.
module axi4lite_read_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // local command side
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    // AXI4-Lite read address channel
    output logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arvalid,
    input  logic                   arready,
    // AXI4-Lite read data channel
    input  logic [pDATA_WIDTH-1:0] rdata,
    input  logic [1:0]             rresp,
    input  logic                   rvalid,
    output logic                   rready,
    // response side
    output logic                   rsp_valid,
    output logic [pDATA_WIDTH-1:0] rsp_data,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic                   busy
);

    localparam int               CNT_W    = $clog2(pTIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pTIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Counter has seen pTIMEOUT stalled cycles once it sits on its last value without a handshake.
    assign tmo_hit   = (tmo_cnt == CNT_LAST);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Transaction sequencer: drives the AR/R handshakes, per-phase timeout and the registered response fields.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= 2'b00;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        araddr      <= cmd_addr;
                        arvalid     <= 1'b1;
                        tmo_cnt     <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= ST_DATA;
                    end else if (tmo_hit) begin
                        // Abandon without handshake; the system is expected to reset the slave.
                        arvalid     <= 1'b0;
                        rready      <= 1'b0;
                        rsp_data    <= '0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rvalid) begin
                        rready      <= 1'b0;
                        rsp_data    <= rdata;
                        rsp_resp    <= rresp;
                        rsp_err     <= (rresp != 2'b00);
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (tmo_hit) begin
                        arvalid     <= 1'b0;
                        rready      <= 1'b0;
                        rsp_data    <= '0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    // rsp_valid was raised on entry and drops here, giving a single-cycle pulse.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_read_master.sv
// Directed bench for axi4lite_read_master with a small AXI slave model and a response scoreboard.
// Latency expectations are derived from slave delay settings; timeout parameter is reduced to 4.
// Slave stalls are configured per step to exercise wait states, errors and both timeout phases.
module tb_axi4lite_read_master;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          axis_clk;
    logic          axis_rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;

    axi4lite_read_master #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .pTIMEOUT    (TMO)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          err;
        logic          tmo;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [AW-1:0] cur_addr = '0;

    // slave model configuration
    int            sl_ar_delay = 0;
    int            sl_r_delay  = 0;
    bit            sl_ar_hang  = 0;
    bit            sl_r_hang   = 0;
    bit            sl_early    = 0;
    logic [DW-1:0] sl_data     = '0;
    logic [1:0]    sl_resp     = 2'b00;

    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    initial begin
        forever begin
            @(posedge axis_clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave: drives ready/valid at the falling edge from per-step delay settings.
    initial begin
        int ar_seen;
        int r_seen;
        ar_seen = 0;
        r_seen  = 0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        forever begin
            @(negedge axis_clk);
            arready = 1'b0;
            rvalid  = 1'b0;
            rdata   = '0;
            rresp   = 2'b00;
            if (arvalid === 1'b1) begin
                arready = (!sl_ar_hang && ar_seen >= sl_ar_delay);
                ar_seen++;
                if (sl_early) begin
                    rvalid = 1'b1;
                    rdata  = 32'hBAD0_BAD0;
                    rresp  = 2'b11;
                end
            end else begin
                ar_seen = 0;
            end
            if (rready === 1'b1) begin
                if (!sl_r_hang && r_seen >= sl_r_delay) begin
                    rvalid = 1'b1;
                    rdata  = sl_data;
                    rresp  = sl_resp;
                end
                r_seen++;
            end else begin
                r_seen = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid and checks channel invariants.
    initial begin
        exp_t e;
        logic prev_rsp;
        prev_rsp = 1'b0;
        forever begin
            @(negedge axis_clk);
            if (arvalid === 1'b1)
                chk("araddr_stable", 64'(araddr), 64'(cur_addr));
            if (axis_rst_n === 1'b1)
                chk("ar_r_exclusive", 64'(arvalid & rready), 64'(0));
            if (prev_rsp)
                chk("rsp_pulse_width", 64'(rsp_valid), 64'(0));
            if (rsp_valid === 1'b1) begin
                chk("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_cycle",   64'(cyc),         64'(e.cyc));
                    chk("rsp_data",    64'(rsp_data),    64'(e.data));
                    chk("rsp_resp",    64'(rsp_resp),    64'(e.resp));
                    chk("rsp_err",     64'(rsp_err),     64'(e.err));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                end
            end
            prev_rsp = (rsp_valid === 1'b1);
        end
    end

    // Returns at the falling edge of the first cycle after accept.
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] r,
                         input logic to, input int lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge axis_clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        chk("cmd_accept_wait", 64'(cmd_ready), 64'(1));
        cur_addr = a;
        e.data = d;
        e.resp = r;
        e.err  = (r != 2'b00);
        e.tmo  = to;
        e.cyc  = cyc + lat;
        exp_q.push_back(e);
        @(negedge axis_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        chk("drain_wait", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int   n;
        int   a1;
        int   a2;
        logic rr_seen;

        axis_rst_n = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;

        // reset state
        repeat (3) @(negedge axis_clk);
        chk("rst_arvalid",   64'(arvalid),     64'(0));
        chk("rst_rready",    64'(rready),      64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid),   64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready),   64'(1));
        chk("rst_busy",      64'(busy),        64'(0));
        chk("rst_araddr",    64'(araddr),      64'(0));
        chk("rst_rsp_data",  64'(rsp_data),    64'(0));
        chk("rst_rsp_tmo",   64'(rsp_timeout), 64'(0));
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        // zero-wait read
        sl_data = 32'h0000_0005;
        sl_resp = 2'b00;
        issue(12'h010, 32'h0000_0005, 2'b00, 1'b0, 3);
        chk("zw_busy_c1",    64'(busy),    64'(1));
        chk("zw_arvalid_c1", 64'(arvalid), 64'(1));
        @(negedge axis_clk);
        chk("zw_busy_c2",    64'(busy),    64'(1));
        chk("zw_rready_c2",  64'(rready),  64'(1));
        @(negedge axis_clk);
        chk("zw_busy_c3",    64'(busy),    64'(1));
        @(negedge axis_clk);
        chk("zw_busy_c4",    64'(busy),    64'(0));
        chk("zw_cmd_ready_c4", 64'(cmd_ready), 64'(1));
        wait_drain();

        // wait-state slave, with stray rvalid during the address phase
        sl_ar_delay = 3;
        sl_r_delay  = 2;
        sl_early    = 1;
        sl_data     = 32'hDEAD_BEEF;
        issue(12'h080, 32'hDEAD_BEEF, 2'b00, 1'b0, 8);
        wait_drain();
        sl_ar_delay = 0;
        sl_r_delay  = 0;
        sl_early    = 0;

        // SLVERR passthrough
        sl_data = 32'h0000_1234;
        sl_resp = 2'b10;
        issue(12'h044, 32'h0000_1234, 2'b10, 1'b0, 3);
        wait_drain();
        sl_resp = 2'b00;

        // reset while in the data phase
        sl_r_hang = 1;
        issue(12'h0C0, 32'h0, 2'b10, 1'b1, 7);
        @(negedge axis_clk);
        chk("mid_rst_in_data", 64'(rready), 64'(1));
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        exp_q.delete();
        chk("mid_rst_arvalid",   64'(arvalid),   64'(0));
        chk("mid_rst_rready",    64'(rready),    64'(0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_rsp_data",  64'(rsp_data),  64'(0));
        chk("mid_rst_rsp_err",   64'(rsp_err),   64'(0));
        axis_rst_n = 1'b1;
        sl_r_hang  = 0;
        repeat (8) @(negedge axis_clk);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // address-phase timeout
        sl_ar_hang = 1;
        issue(12'h0F0, 32'h0, 2'b10, 1'b1, TMO + 1);
        n       = 0;
        rr_seen = 1'b0;
        while (arvalid === 1'b1 && n < 20) begin
            if (rready === 1'b1) rr_seen = 1'b1;
            n++;
            @(negedge axis_clk);
        end
        chk("atmo_arvalid_cycles", 64'(n),         64'(TMO));
        chk("atmo_rready_never",   64'(rr_seen),   64'(0));
        chk("atmo_rsp_next",       64'(rsp_valid), 64'(1));
        sl_ar_hang = 0;
        wait_drain();

        // normal read after timeout clears rsp_timeout
        sl_data = 32'hCAFE_0001;
        issue(12'h0A0, 32'hCAFE_0001, 2'b00, 1'b0, 3);
        chk("post_tmo_cleared", 64'(rsp_timeout), 64'(0));
        wait_drain();

        // data-phase timeout
        sl_ar_delay = 1;
        sl_r_hang   = 1;
        issue(12'h0B4, 32'h0, 2'b10, 1'b1, 3 + 1 + TMO - 1);
        wait_drain();
        sl_ar_delay = 0;
        sl_r_hang   = 0;

        // back-to-back with cmd_valid held high
        sl_data = 32'h0000_0077;
        @(negedge axis_clk);
        cmd_valid = 1'b1;
        cmd_addr  = 12'h000;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        a1       = cyc;
        cur_addr = 12'h000;
        exp_q.push_back('{32'h0000_0077, 2'b00, 1'b0, 1'b0, a1 + 3});
        @(negedge axis_clk);
        cmd_addr = 12'h004;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        a2       = cyc;
        cur_addr = 12'h004;
        exp_q.push_back('{32'h0000_0077, 2'b00, 1'b0, 1'b0, a2 + 3});
        chk("b2b_spacing", 64'(a2 - a1), 64'(4));
        @(negedge axis_clk);
        cmd_valid = 1'b0;
        wait_drain();
        repeat (6) @(negedge axis_clk);
        chk("b2b_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi4lite_read_master.md
# axi4lite_read_master

AXI4-Lite read initiator that turns a single-entry command request into one AXI4-Lite read transaction and returns the read data with response status. It sits between local control logic (test sequencer or configuration loader) and any AXI4-Lite read responder in the FIR subsystem, such as the FIR configuration register port. Only one transaction is in flight at a time. A per-phase timeout counter ensures that a non-responding slave cannot hang the initiator.

## Interface
- pADDR_WIDTH, 12, address width
- pDATA_WIDTH, 32, data width
- pTIMEOUT, 255, cycles waited in each of ADDR and DATA before abort (≥1, counter width $clog2(pTIMEOUT+1))
- axis_clk  in  1  clock, all logic on rising edge
- axis_rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  initiator idle, command accepted when cmd_valid&cmd_ready
- cmd_addr  in  pADDR_WIDTH  read address
- araddr  out  pADDR_WIDTH  AXI read address
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rdata  in  pDATA_WIDTH  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI data valid
- rready  out  1  AXI data ready
- rsp_valid  out  1  one-cycle pulse, response fields valid
- rsp_data  out  pDATA_WIDTH  captured rdata
- rsp_resp  out  2  captured rresp (2'b10 on timeout)
- rsp_err  out  1  rresp≠OKAY or timeout
- rsp_timeout  out  1  transaction aborted by timeout
- busy  out  1  state≠IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, RESP; all outputs except cmd_ready and busy are registered.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_addr into araddr, set arvalid=1, clear the timeout counter, go to ADDR.
- ADDR: arvalid=1 and araddr held stable. On arready=1: arvalid←0, rready←1, clear the counter, go to DATA. Otherwise the counter increments. When the counter reaches pTIMEOUT-1 without arready, the transaction aborts.
- DATA: rready=1. On rvalid=1: capture rdata into rsp_data and rresp into rsp_resp, rready←0, go to RESP. The timeout rule is the same as in ADDR.
- RESP: rsp_valid=1 for exactly one cycle. rsp_err=(rsp_resp≠2'b00). The FSM returns to IDLE.
- Abort (ADDR or DATA timeout): arvalid←0, rready←0, rsp_data←0, rsp_resp←2'b10, rsp_err←1, rsp_timeout←1, go to RESP. On abort, arvalid or rready drops without a handshake. This is deliberate recovery behaviour, and the slave is expected to be reset by the system.
- rsp_data, rsp_resp, rsp_err and rsp_timeout hold their values until the next capture. rsp_timeout is cleared on the next command accept.
- cmd_valid is ignored outside IDLE. No queueing.
- Reset (axis_rst_n=0 at a rising edge) from any state: state←IDLE. arvalid, rready and rsp_valid←0. araddr, rsp_data, rsp_resp, rsp_err and rsp_timeout←0. Counter←0. No response is emitted for an interrupted transaction.

## Timing
- Cycle 0: command accepted.
- Cycle 1: arvalid=1.
- Zero-wait slave (arready high at cycle 1, rvalid high at cycle 2): rready=1 at cycle 2, rsp_valid at cycle 3. Minimum latency is 3 cycles from command accept to rsp_valid.
- cmd_ready reasserts in the cycle after rsp_valid. Minimum command-to-command spacing is 4 cycles.
- Each slave wait cycle in ADDR or DATA adds one cycle of latency.
- Timeout fires after pTIMEOUT consecutive cycles without a handshake in the current phase. rsp_valid is asserted the following cycle.
- arvalid and rready are never high in the same cycle.
- arvalid is high for ≥1 cycle per transaction. rready is high for ≥1 cycle per transaction, except on an ADDR-phase abort, where it never rises.
- rvalid arriving while in ADDR is ignored. Data is only sampled in DATA.

## Test plan
- Zero-wait read: cmd_addr=12'h010, slave returns rdata=32'h0000_0005 and rresp=00 immediately. Required: rsp_valid at cycle 3 with rsp_data=5, rsp_err=0, busy high during cycles 1–3.
- Wait-state slave: arready delayed 3 cycles, rvalid delayed 2 cycles, addr 12'h080, data 32'hDEAD_BEEF. Required: araddr stable while arvalid, rsp_valid at cycle 8, rsp_data=DEADBEEF.
- SLVERR: rresp=2'b10, rdata=32'h1234. Required: rsp_err=1, rsp_resp=10, rsp_timeout=0, rsp_data=32'h1234.
- Timeout with pTIMEOUT=4 and arready held low. Required: arvalid high for 4 cycles then low, rsp_valid one cycle later, rsp_timeout=1, rsp_data=0. The next command then completes normally with rsp_timeout cleared.
- Back-to-back: cmd_valid held high for addresses 0x00 then 0x04. Required: second accept exactly 4 cycles after the first; cmd_valid ignored while busy.
- Reset mid-operation: assert axis_rst_n=0 in DATA. Required: next edge gives arvalid=rready=rsp_valid=0 and cmd_ready=1 after release, with no spurious rsp_valid.
